tap_controller: RTL and testbench



---
 rtl/tap_controller_if.sv | 29 ++
 rtl/tap_controller.sv | 119 +++++++++++
 tb/tb_tap_controller.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tap_controller_if.sv
// JTAG pin-side signals of the TAP controller: TMS in, decoded scan-chain strobes out.
// The controller takes the slave modport; pin drivers / benches take the master modport.
interface tap_controller_if;
    logic tms;
    logic reset;
    logic tdo_en;
    logic shiftIR;
    logic shiftDR;
    logic captureIR;
    logic captureDR;
    logic clockIR;
    logic clockDR;
    logic updateIR;
    logic updateDR;
    logic updateDRstate;
    logic select;

    modport master (
        output tms,
        input  reset, tdo_en, shiftIR, shiftDR, captureIR, captureDR,
        input  clockIR, clockDR, updateIR, updateDR, updateDRstate, select
    );

    modport slave (
        input  tms,
        output reset, tdo_en, shiftIR, shiftDR, captureIR, captureDR,
        output clockIR, clockDR, updateIR, updateDR, updateDRstate, select
    );
endinterface

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: 16-state FSM on rising tck, falling-edge registered
// shift/enable outputs, glitch-free gated scan clocks and half-cycle update strobes.
module tap_controller (
    input  logic             tck,
    input  logic             trst,
    tap_controller_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR    = 4'hF,
        RTI    = 4'hC,
        SEL_DR = 4'h7,
        CAP_DR = 4'h6,
        SH_DR  = 4'h2,
        EX1_DR = 4'h1,
        PAU_DR = 4'h3,
        EX2_DR = 4'h0,
        UPD_DR = 4'h5,
        SEL_IR = 4'h4,
        CAP_IR = 4'hE,
        SH_IR  = 4'hA,
        EX1_IR = 4'h9,
        PAU_IR = 4'hB,
        EX2_IR = 4'h8,
        UPD_IR = 4'hD
    } tap_state_e;

    tap_state_e state_q;
    tap_state_e state_d;
    logic       clk_ir_en_q;
    logic       clk_ir_en_d;
    logic       clk_dr_en_q;
    logic       clk_dr_en_d;
    logic       reset_q;
    logic       reset_d;
    logic       tdo_en_q;
    logic       tdo_en_d;
    logic       shift_ir_q;
    logic       shift_ir_d;
    logic       shift_dr_q;
    logic       shift_dr_d;

    always_comb begin
        state_d = TLR;
        unique case (state_q)
            TLR:     state_d = jtag.tms ? TLR    : RTI;
            RTI:     state_d = jtag.tms ? SEL_DR : RTI;
            SEL_DR:  state_d = jtag.tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = jtag.tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = jtag.tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = jtag.tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = jtag.tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = jtag.tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = jtag.tms ? SEL_DR : RTI;
            SEL_IR:  state_d = jtag.tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = jtag.tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = jtag.tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = jtag.tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = jtag.tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = jtag.tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = jtag.tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Gate enables are flopped on the rising edge so they only move while tck is high.
    always_comb begin
        clk_ir_en_d = (state_d == CAP_IR) || (state_d == SH_IR);
        clk_dr_en_d = (state_d == CAP_DR) || (state_d == SH_DR);
    end

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            state_q     <= TLR;
            clk_ir_en_q <= 1'b0;
            clk_dr_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_ir_en_q <= clk_ir_en_d;
            clk_dr_en_q <= clk_dr_en_d;
        end
    end

    always_comb begin
        reset_d    = (state_q != TLR);
        shift_ir_d = (state_q == SH_IR);
        shift_dr_d = (state_q == SH_DR);
        tdo_en_d   = (state_q == SH_IR) || (state_q == SH_DR);
    end

    // Half-cycle lag keeps these stable across the rising edge that consumes them.
    always_ff @(negedge tck or negedge trst) begin
        if (!trst) begin
            reset_q    <= 1'b0;
            tdo_en_q   <= 1'b0;
            shift_ir_q <= 1'b0;
            shift_dr_q <= 1'b0;
        end else begin
            reset_q    <= reset_d;
            tdo_en_q   <= tdo_en_d;
            shift_ir_q <= shift_ir_d;
            shift_dr_q <= shift_dr_d;
        end
    end

    assign jtag.reset         = reset_q;
    assign jtag.tdo_en        = tdo_en_q;
    assign jtag.shiftIR       = shift_ir_q;
    assign jtag.shiftDR       = shift_dr_q;
    assign jtag.captureIR     = (state_q == CAP_IR);
    assign jtag.captureDR     = (state_q == CAP_DR);
    assign jtag.clockIR       = tck | ~clk_ir_en_q;
    assign jtag.clockDR       = tck | ~clk_dr_en_q;
    assign jtag.updateIR      = ~tck & (state_q == UPD_IR);
    assign jtag.updateDR      = ~tck & (state_q == UPD_DR);
    assign jtag.updateDRstate = (state_q == UPD_DR);
    assign jtag.select        = state_q[3];

endmodule

// File: tb/tb_tap_controller.sv
// Scoreboard bench for tap_controller: directed TMS walks push expected states,
// a monitor checks every output in both tck phases of each expected cycle.
module tb_tap_controller;

    typedef enum logic [3:0] {
        S_TLR = 4'hF, S_RTI = 4'hC, S_SELDR = 4'h7, S_CAPDR = 4'h6,
        S_SHDR = 4'h2, S_EX1DR = 4'h1, S_PAUDR = 4'h3, S_EX2DR = 4'h0,
        S_UPDDR = 4'h5, S_SELIR = 4'h4, S_CAPIR = 4'hE, S_SHIR = 4'hA,
        S_EX1IR = 4'h9, S_PAUIR = 4'hB, S_EX2IR = 4'h8, S_UPDIR = 4'hD
    } st_e;

    typedef struct {
        int  cyc;
        int  id;
        st_e cur;
        st_e prev;
    } exp_t;

    logic tck;
    logic trst;
    tap_controller_if jif ();

    tap_controller u_dut (
        .tck  (tck),
        .trst (trst),
        .jtag (jif)
    );

    initial tck = 1'b0;
    always #10 tck = ~tck;

    exp_t sb_q[$];
    int   cyc_cnt  = 0;
    int   checks   = 0;
    int   failures = 0;
    int   txn_id   = 0;
    st_e  cur_st   = S_TLR;

    // {reset,tdo_en,shiftIR,shiftDR,captureIR,captureDR,clockIR,clockDR,updateIR,updateDR,updateDRstate,select}
    function automatic logic [11:0] dut_vec();
        return {jif.reset, jif.tdo_en, jif.shiftIR, jif.shiftDR, jif.captureIR, jif.captureDR,
                jif.clockIR, jif.clockDR, jif.updateIR, jif.updateDR, jif.updateDRstate, jif.select};
    endfunction

    // low=1: sample in tck-low half of cur; low=0: tck-high half, flops still hold prev.
    function automatic logic [11:0] exp_vec(st_e cur, st_e prev, bit low);
        st_e  src;
        logic sel;
        src = low ? cur : prev;
        sel = (cur == S_TLR) || (cur == S_RTI) || (cur == S_CAPIR) || (cur == S_SHIR) ||
              (cur == S_EX1IR) || (cur == S_PAUIR) || (cur == S_EX2IR) || (cur == S_UPDIR);
        return {src != S_TLR,
                (src == S_SHIR) || (src == S_SHDR),
                src == S_SHIR,
                src == S_SHDR,
                cur == S_CAPIR,
                cur == S_CAPDR,
                low ? !((cur == S_CAPIR) || (cur == S_SHIR)) : 1'b1,
                low ? !((cur == S_CAPDR) || (cur == S_SHDR)) : 1'b1,
                low && (cur == S_UPDIR),
                low && (cur == S_UPDDR),
                cur == S_UPDDR,
                sel};
    endfunction

    task automatic check_vec(input string name, input int id, input st_e st,
                             input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s txn=%0d state=%s got=%b required=%b", name, id, st.name(), got, exp);
        end
    endtask

    // Monitor: pops one expectation per scheduled cycle and checks both phases.
    initial begin
        exp_t e;
        forever begin
            @(posedge tck);
            cyc_cnt++;
            #5;
            while (sb_q.size() != 0 && sb_q[0].cyc < cyc_cnt) begin
                checks++;
                failures++;
                $display("FAIL missed_txn txn=%0d got_cycle=%0d required_cycle=%0d",
                         sb_q[0].id, cyc_cnt, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() != 0 && sb_q[0].cyc == cyc_cnt) begin
                logic [11:0] hi_v;
                logic [11:0] lo_v;
                e = sb_q[0];
                hi_v = dut_vec();
                check_vec("tck_high", e.id, e.cur, hi_v, exp_vec(e.cur, e.prev, 1'b0));
                @(negedge tck);
                #5;
                lo_v = dut_vec();
                check_vec("tck_low", e.id, e.cur, lo_v, exp_vec(e.cur, e.prev, 1'b1));
                $display("txn %0d tms=%0b state=%s hi=%b lo=%b", e.id, jif.tms, e.cur.name(), hi_v, lo_v);
                void'(sb_q.pop_front());
            end
        end
    end

    task automatic step(input bit t, input st_e nxt);
        exp_t e;
        @(negedge tck);
        jif.tms = t;
        e.cyc  = cyc_cnt + 1;
        e.id   = txn_id;
        e.cur  = nxt;
        e.prev = cur_st;
        txn_id++;
        sb_q.push_back(e);
        cur_st = nxt;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge tck);
            #6;
            n++;
        end while (sb_q.size() != 0 && n < 20);
    endtask

    // Asserts trst in the low half of a cycle, checks the abort, releases while tck is high.
    task automatic trst_pulse(input string name);
        drain();
        #1;
        trst = 1'b0;
        #1;
        check_vec({name, "_assert"}, -1, S_TLR, dut_vec(), exp_vec(S_TLR, S_TLR, 1'b1));
        @(posedge tck);
        #4;
        check_vec({name, "_held"}, -1, S_TLR, dut_vec(), exp_vec(S_TLR, S_TLR, 1'b0));
        #1;
        trst = 1'b1;
        cur_st = S_TLR;
    endtask

    initial begin
        jif.tms = 1'b1;
        trst    = 1'b1;
        #1 trst = 1'b0;
        #2;
        check_vec("power_on_reset", -1, S_TLR, dut_vec(), exp_vec(S_TLR, S_TLR, 1'b1));
        #12 trst = 1'b1;

        // tms=1 held: stays in Test-Logic-Reset
        for (int i = 0; i < 9; i++) step(1'b1, S_TLR);

        // mid-cycle trst from RTI
        step(1'b0, S_RTI);
        step(1'b0, S_RTI);
        trst_pulse("trst_rti");

        // IR scan
        step(1'b0, S_RTI);   step(1'b1, S_SELDR); step(1'b1, S_SELIR); step(1'b0, S_CAPIR);
        step(1'b0, S_SHIR);  step(1'b0, S_SHIR);  step(1'b0, S_SHIR);  step(1'b1, S_EX1IR);
        step(1'b1, S_UPDIR); step(1'b0, S_RTI);

        // DR scan with pause
        step(1'b1, S_SELDR); step(1'b0, S_CAPDR); step(1'b0, S_SHDR);  step(1'b1, S_EX1DR);
        step(1'b0, S_PAUDR); step(1'b0, S_PAUDR); step(1'b1, S_EX2DR); step(1'b0, S_SHDR);
        step(1'b1, S_EX1DR); step(1'b1, S_UPDDR); step(1'b0, S_RTI);

        // five ones from ShDR
        step(1'b1, S_SELDR); step(1'b0, S_CAPDR); step(1'b0, S_SHDR);
        step(1'b1, S_EX1DR); step(1'b1, S_UPDDR); step(1'b1, S_SELDR); step(1'b1, S_SELIR);
        step(1'b1, S_TLR);

        // SelIR escape
        step(1'b0, S_RTI);   step(1'b1, S_SELDR); step(1'b1, S_SELIR); step(1'b1, S_TLR);

        // trst during ShIR
        step(1'b0, S_RTI);   step(1'b1, S_SELDR); step(1'b1, S_SELIR); step(1'b0, S_CAPIR);
        step(1'b0, S_SHIR);  step(1'b0, S_SHIR);
        trst_pulse("trst_shir");
        step(1'b0, S_RTI);   step(1'b0, S_RTI);

        // remaining IR/DR branches: pause/exit2 and capture-to-exit paths
        step(1'b1, S_SELDR); step(1'b1, S_SELIR); step(1'b0, S_CAPIR); step(1'b1, S_EX1IR);
        step(1'b0, S_PAUIR); step(1'b0, S_PAUIR); step(1'b1, S_EX2IR); step(1'b0, S_SHIR);
        step(1'b1, S_EX1IR); step(1'b1, S_UPDIR); step(1'b1, S_SELDR); step(1'b0, S_CAPDR);
        step(1'b1, S_EX1DR); step(1'b0, S_PAUDR); step(1'b1, S_EX2DR); step(1'b1, S_UPDDR);
        step(1'b1, S_SELDR); step(1'b1, S_SELIR); step(1'b0, S_CAPIR); step(1'b1, S_EX1IR);
        step(1'b0, S_PAUIR); step(1'b1, S_EX2IR); step(1'b1, S_UPDIR); step(1'b0, S_RTI);

        drain();
        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
